// File: rtl/stack_if.sv
// Handshake and result bundle between the control FSM and the stack-pointer
// burst unit; the unit itself uses the slave modport.
interface stack_if #(
   parameter int WIDTH    = 8,
   parameter int PAGE_W   = 8,
   parameter int MAXBURST = 3
);
   localparam int CW = $clog2(MAXBURST + 1);

   logic                    load;
   logic [WIDTH-1:0]        in;
   logic                    start;
   logic                    dir;
   logic [CW-1:0]           count;
   logic                    busy;
   logic                    step;
   logic [PAGE_W+WIDTH-1:0] addr;
   logic                    done;
   logic                    wrap;
   logic                    wrap_err;
   logic [WIDTH-1:0]        out;

   modport master (
      output load, in, start, dir, count,
      input  busy, step, addr, done, wrap, wrap_err, out
   );

   modport slave (
      input  load, in, start, dir, count,
      output busy, step, addr, done, wrap, wrap_err, out
   );
endinterface

// File: rtl/stack_seq.sv
// 6502-style stack pointer with a fixed page and a 1..MAXBURST byte
// push/pull sequencer that emits one stack bus address per clock.
module stack_seq #(
   parameter int                WIDTH     = 8,
   parameter int                PAGE_W    = 8,
   parameter logic [PAGE_W-1:0] PAGE      = 8'h01,
   parameter logic [WIDTH-1:0]  RESET_VAL = 8'hFF,
   parameter int                MAXBURST  = 3
) (
   input logic     clk,
   input logic     rst,
   stack_if.slave  bus
);
   localparam int CW = $clog2(MAXBURST + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             dir_q, dir_d;
   logic [CW-1:0]    rem_q, rem_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] s_inc;
   logic [CW-1:0]    req_len;
   logic             wrap_now;

   assign s_inc    = s_q + WIDTH'(1);
   // A step wraps when a push leaves 0 or a pull leaves all-ones.
   assign wrap_now = (state_q == RUN) && (dir_q ? (&s_q) : (s_q == '0));
   assign req_len  = (int'(bus.count) > MAXBURST) ? CW'(MAXBURST) : bus.count;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; the comb block below uses blocking assignments.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= RESET_VAL;
         dir_q   <= 1'b0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d = state_q;
      s_d     = s_q;
      dir_d   = dir_q;
      rem_d   = rem_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE: begin
            if (bus.load) begin
               s_d   = bus.in;
               err_d = 1'b0;
            end else if (bus.start && (bus.count != '0)) begin
               dir_d   = bus.dir;
               rem_d   = req_len;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d   = dir_q ? s_inc : (s_q - WIDTH'(1));
            rem_d = rem_q - CW'(1);
            if (wrap_now)
               err_d = 1'b1;
            if (rem_q == CW'(1))
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pull addresses the byte above S (increment-then-read); push addresses S.
   assign bus.busy     = (state_q != IDLE);
   assign bus.step     = (state_q == RUN);
   assign bus.addr     = {PAGE, ((state_q == RUN) && dir_q) ? s_inc : s_q};
   assign bus.done     = (state_q == DONE);
   assign bus.wrap     = wrap_now;
   assign bus.wrap_err = err_q;
   assign bus.out      = s_q;
endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: directed scenarios plus randomized bursts
// against a plain-arithmetic model of the stack pointer.
module tb_stack_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   stack_if #(.WIDTH(8), .PAGE_W(8), .MAXBURST(3)) bus ();

   stack_seq #(
      .WIDTH(8), .PAGE_W(8), .PAGE(8'h01), .RESET_VAL(8'hFF), .MAXBURST(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ms     = 255;   // model stack pointer
   bit merr   = 1'b0;  // model sticky wrap flag

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.load  = 1'b0;
      bus.in    = '0;
      bus.start = 1'b0;
      bus.dir   = 1'b0;
      bus.count = '0;
   endtask

   task automatic do_load(input int v);
      bus.load = 1'b1;
      bus.in   = 8'(v);
      tick();
      bus.load = 1'b0;
      ms   = v & 255;
      merr = 1'b0;
      checks++; if (bus.out !== 8'(ms)) begin errors++; $display("FAIL load_out got=%h exp=%h", bus.out, 8'(ms)); end
      checks++; if (bus.wrap_err !== 1'b0) begin errors++; $display("FAIL load_err got=%b exp=0", bus.wrap_err); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL load_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic noise();
      bus.start = 1'($urandom);
      bus.load  = 1'($urandom);
      bus.in    = 8'($urandom);
      bus.dir   = 1'($urandom);
      bus.count = 2'($urandom);
   endtask

   // Runs one burst from IDLE and checks each cycle against the model.
   task automatic do_burst(input bit d, input int n, input bit noisy);
      logic [15:0] ea;
      bit          ew;
      bus.load  = 1'b0;
      bus.start = 1'b1;
      bus.dir   = d;
      bus.count = 2'(n);
      tick();
      clear_inputs();
      for (int i = 0; i < n; i++) begin
         if (noisy) noise();
         if (!d) begin
            ea = {8'h01, 8'(ms)};
            ew = (ms == 0);
            ms = (ms - 1) & 255;
         end else begin
            ms = (ms + 1) & 255;
            ea = {8'h01, 8'(ms)};
            ew = (ms == 0);
         end
         if (ew) merr = 1'b1;
         checks++; if (bus.step !== 1'b1) begin errors++; $display("FAIL burst_step[%0d] got=%b exp=1", i, bus.step); end
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL burst_busy[%0d] got=%b exp=1", i, bus.busy); end
         checks++; if (bus.addr !== ea) begin errors++; $display("FAIL burst_addr[%0d] got=%h exp=%h", i, bus.addr, ea); end
         checks++; if (bus.wrap !== ew) begin errors++; $display("FAIL burst_wrap[%0d] got=%b exp=%b", i, bus.wrap, ew); end
         checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL burst_early_done[%0d] got=%b exp=0", i, bus.done); end
         tick();
      end
      if (noisy) noise();
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_pulse got=%b exp=1", bus.done); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL done_busy got=%b exp=1", bus.busy); end
      checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL done_step got=%b exp=0", bus.step); end
      checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL done_wrap got=%b exp=0", bus.wrap); end
      tick();
      clear_inputs();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL idle_done got=%b exp=0", bus.done); end
      checks++; if (bus.out !== 8'(ms)) begin errors++; $display("FAIL idle_out got=%h exp=%h", bus.out, 8'(ms)); end
      checks++; if (bus.wrap_err !== merr) begin errors++; $display("FAIL idle_wrap_err got=%b exp=%b", bus.wrap_err, merr); end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      repeat (2) tick();
      checks++; if (bus.out !== 8'hFF) begin errors++; $display("FAIL rst_hold_out got=%h exp=ff", bus.out); end
      rst = 1'b0;
      tick();
      ms = 255; merr = 1'b0;
      checks++; if (bus.out !== 8'hFF) begin errors++; $display("FAIL rst_out got=%h exp=ff", bus.out); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL rst_step got=%b exp=0", bus.step); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
      checks++; if (bus.wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap got=%b exp=0", bus.wrap); end
      checks++; if (bus.wrap_err !== 1'b0) begin errors++; $display("FAIL rst_wrap_err got=%b exp=0", bus.wrap_err); end
      checks++; if (bus.addr !== 16'h01FF) begin errors++; $display("FAIL rst_addr got=%h exp=01ff", bus.addr); end
   endtask

   task automatic test_push();
      do_burst(1'b0, 2, 1'b0);
      checks++; if (bus.out !== 8'hFD) begin errors++; $display("FAIL push_final got=%h exp=fd", bus.out); end
   endtask

   task automatic test_pull();
      do_load(8'hFA);
      do_burst(1'b1, 3, 1'b0);
      checks++; if (bus.out !== 8'hFD) begin errors++; $display("FAIL pull_final got=%h exp=fd", bus.out); end
   endtask

   task automatic test_push_wrap();
      do_load(8'h00);
      do_burst(1'b0, 1, 1'b0);
      checks++; if (bus.wrap_err !== 1'b1) begin errors++; $display("FAIL push_wrap_err got=%b exp=1", bus.wrap_err); end
      do_load(8'h10);
   endtask

   task automatic test_pull_wrap();
      do_load(8'hFE);
      do_burst(1'b1, 2, 1'b0);
      checks++; if (bus.out !== 8'h00) begin errors++; $display("FAIL pull_wrap_out got=%h exp=00", bus.out); end
   endtask

   task automatic test_ignored();
      bus.load = 1'b1; bus.in = 8'h42; bus.start = 1'b1; bus.dir = 1'b0; bus.count = 2'd2;
      tick();
      clear_inputs();
      ms = 8'h42; merr = 1'b0;
      checks++; if (bus.out !== 8'h42) begin errors++; $display("FAIL load_vs_start_out got=%h exp=42", bus.out); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL load_vs_start_busy got=%b exp=0", bus.busy); end
      tick();
      checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL load_vs_start_step got=%b exp=0", bus.step); end
      bus.start = 1'b1; bus.count = 2'd0; bus.dir = 1'b1;
      tick();
      clear_inputs();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL count0_busy got=%b exp=0", bus.busy); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL count0_done got=%b exp=0", bus.done); end
      checks++; if (bus.out !== 8'h42) begin errors++; $display("FAIL count0_out got=%h exp=42", bus.out); end
      do_burst(1'b0, 3, 1'b1);
      do_burst(1'b1, 2, 1'b1);
   endtask

   task automatic test_reset_mid_burst();
      do_load(8'h80);
      bus.start = 1'b1; bus.dir = 1'b0; bus.count = 2'd3;
      tick();
      clear_inputs();
      checks++; if (bus.addr !== 16'h0180) begin errors++; $display("FAIL mid_first_addr got=%h exp=0180", bus.addr); end
      tick();
      rst = 1'b1;
      #1;
      checks++; if (bus.out !== 8'hFF) begin errors++; $display("FAIL mid_rst_out got=%h exp=ff", bus.out); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL mid_rst_step got=%b exp=0", bus.step); end
      #2;
      rst = 1'b0;
      ms = 255; merr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (bus.step !== 1'b0) begin errors++; $display("FAIL post_rst_step[%0d] got=%b exp=0", i, bus.step); end
         checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL post_rst_done[%0d] got=%b exp=0", i, bus.done); end
         checks++; if (bus.out !== 8'hFF) begin errors++; $display("FAIL post_rst_out[%0d] got=%h exp=ff", i, bus.out); end
      end
   endtask

   task automatic test_random();
      int edge_vals[5] = '{0, 1, 254, 255, 0};
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            edge_vals[4] = int'($urandom_range(0, 255));
            do_load(edge_vals[$urandom_range(0, 4)]);
         end
         do_burst(1'($urandom), int'($urandom_range(1, 3)), 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_push();
      test_pull();
      test_push_wrap();
      test_pull_wrap();
      test_ignored();
      test_reset_mid_burst();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
